// File: rtl/alu_share_arbiter_if.sv
// Requester/responder handshakes and shared ALU hookup
// for the two-port ALU share arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_cout;

    logic [2:0]       alu_s;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_d;
    logic             alu_cout;

    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        output alu_d, alu_cout,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid,
        input  resp_data, resp_cout,
        input  alu_s, alu_a, alu_b,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        input  alu_d, alu_cout,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid,
        output resp_data, resp_cout,
        output alu_s, alu_a, alu_b,
        output busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two
// requesters; one op in flight, registered operands and result.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] RESP  = 2'b10;

    localparam logic [2:0] OP_ZERO = 3'b111;

    logic [1:0]       state;
    logic             last_grant;
    logic             owner;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             cout_q;

    logic             idle;
    logic             any_req;
    logic             grant;
    logic             take;
    logic             is_arith;

    assign idle    = (state == IDLE);
    assign any_req = bus.req0_valid | bus.req1_valid;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (bus.req0_valid & bus.req1_valid):
                grant = ~last_grant;
            (bus.req1_valid & ~bus.req0_valid):
                grant = 1'b1;
            default:
                grant = 1'b0;
        endcase
    end

    assign bus.req0_ready = idle & bus.req0_valid & ~grant;
    assign bus.req1_ready = idle & bus.req1_valid & grant;

    assign take = owner ? bus.resp1_ready : bus.resp0_ready;

    // Only add/sub produce a meaningful carry.
    assign is_arith = (op_q[2:1] == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= OP_ZERO;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            cout_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        op_q       <= grant ? bus.req1_op : bus.req0_op;
                        a_q        <= grant ? bus.req1_a  : bus.req0_a;
                        b_q        <= grant ? bus.req1_b  : bus.req0_b;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    data_q <= bus.alu_d;
                    cout_q <= is_arith & bus.alu_cout;
                    state  <= RESP;
                end
                RESP: begin
                    if (take) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The shared ALU sees a zero op unless we are issuing.
    assign bus.alu_s = (state == ISSUE) ? op_q : OP_ZERO;
    assign bus.alu_a = (state == ISSUE) ? a_q  : '0;
    assign bus.alu_b = (state == ISSUE) ? b_q  : '0;

    assign bus.resp0_valid = (state == RESP) & ~owner;
    assign bus.resp1_valid = (state == RESP) & owner;
    assign bus.resp_data   = data_q;
    assign bus.resp_cout   = cout_q;
    assign bus.busy        = ~idle;
endmodule
